ssit_update_ctrl: RTL and testbench
===================================

# ssit_update_ctrl

Write-side controller for the store set ID table (SSIT): accepts memory-order-violation and device-violation training requests from the load/store unit, merges store sets, allocates new store set IDs, and arbitrates the SSIT's two write ports. It also runs an initialization/periodic clear sweep that zeroes every SSIT entry. It sits between the LSU violation-detection logic and the dual-port SSIT SRAM; SSIT read ports are untouched.

## Interface
- FIFO_DEPTH, 4, violation request queue depth (power of 2, ≥2)
- CLEAR_INTERVAL, 65536, cycles in IDLE between automatic clear sweeps
- SSIT_WIDTH, LFST_WIDTH: taken from Falco_pkg, not parameters
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- viol_valid  in  1  violation training request
- viol_ready  out  1  queue not full
- viol_ld_pc, viol_st_pc  in  SSIT_WIDTH  hashed PCs of the load and the store
- viol_ld_id, viol_st_id  in  LFST_WIDTH  their current SSIT IDs (0 = no set)
- dev_valid  in  1  device-access violation request
- dev_ready  out  1  device holding register empty
- dev_pc  in  SSIT_WIDTH  PC to pin to device set
- clear_req  in  1  pulse: force a clear sweep
- wr_a_en, wr_b_en  out  1  SSIT port A/B write enable
- wr_a_addr, wr_b_addr  out  SSIT_WIDTH  write addresses
- wr_a_data, wr_b_data  out  LFST_WIDTH  write data
- clearing  out  1  sweep in progress; consumers treat all SSIT lookups as ID 0

## Operation
- States: CLEAR, IDLE. Reset state CLEAR, sweep index 0, interval counter 0, allocator 2, FIFO empty, device register empty.
- CLEAR: each cycle write 0 to addr 2k (port A) and 2k+1 (port B), k = 0 … 2^(SSIT_WIDTH-1)-1; after last pair → IDLE, interval counter 0, allocator 2. No training writes issue in CLEAR; requests still accepted while space remains.
- IDLE: interval counter increments; on reaching CLEAR_INTERVAL-1, or on clear_req, → CLEAR next cycle. clear_req during CLEAR ignored.
- Issue priority in IDLE, one request per cycle: device register, then FIFO head.
- Device: port A writes dev_pc ← 1 (SSIT_DEVICE_ID).
- Violation merge, from head entry:
  - both IDs 0: port A ld_pc ← alloc, port B st_pc ← alloc; allocator advances.
  - exactly one 0: single port-A write of the zero-ID PC ← the nonzero ID.
  - both nonzero, unequal: port-A write of the smaller-ID PC ← the larger ID.
  - equal nonzero: entry popped, no write.
  - An ID of 1 is treated as an ordinary nonzero ID.
- Allocator: 2 … 2^LFST_WIDTH-1, then wraps to 2; never produces 0 or 1.
- Same-cycle viol and dev acceptance is permitted; both are taken.
- Queued entries survive a sweep and issue after it.

## Timing
- Handshake: transfer when valid & ready at a rising edge. Ready depends only on occupancy, never on valid.
- Latency: request accepted at edge T, with no contention → write outputs asserted during cycle T+1→T+2, i.e. registered; 2 edges minimum.
- All wr_* outputs are registered; reset value 0.
- clearing is decoded from state: 1 during reset and the sweep; 0 in IDLE.
- Sweep length after reset is exactly 2^(SSIT_WIDTH-1) cycles of write pairs.
- A full FIFO drops viol_ready in the cycle after the filling transfer. Pop and push in the same cycle keep the count unchanged.
- rst mid-sweep or mid-queue discards everything and restarts the sweep at index 0.

## Structure
- Falco_pkg: typedef ssit_viol_t {ld_pc, st_pc, ld_id, st_id}; constants SSIT_DEVICE_ID=1, SSIT_FIRST_ALLOC_ID=2; state enum ssit_ctrl_state_t.
- Sub-module: sync_fifo (parameterized width/depth, full/empty/count) holding ssit_viol_t.
- FSM, allocator, interval counter, and issue mux stay in ssit_update_ctrl.

## Test plan
- Reset with SSIT_WIDTH=10:
  - clearing high for 512 cycles.
  - Pairs (0,1) … (1022,1023) written with data 0.
  - Then clearing=0.
- Violation ld_id=0, st_id=0, ld_pc=5, st_pc=9: both ports write ID 2 two edges later. Second such violation writes ID 3.
- Violation ld_id=7, st_id=4 (pcs 20, 30): single port-A write addr 30 ← 7. Equal IDs 6/6: no write, entry popped.
- Device, same cycle as violation (0,0):
  - dev_pc=40 ← 1 issues first.
  - The violation issues the next cycle.
  - Both readies remain 1.
- Allocator at 2047 with an all-zero violation: writes 2047, next allocation 2. Fill FIFO with 5 back-to-back requests during a sweep: viol_ready=0 after 4; all 4 applied after the sweep.
- Apply clear_req in IDLE, then rst at sweep index 100: sweep restarts at index 0, FIFO empty, outputs 0.

Source files
------------

// File: rtl/Falco_pkg.sv
// Shared SSIT/LFST widths, training request record and controller state
// encoding for the store set ID table write path.
package Falco_pkg;

    localparam int SSIT_WIDTH = 10;
    localparam int LFST_WIDTH = 11;

    localparam logic [LFST_WIDTH-1:0] SSIT_DEVICE_ID      = LFST_WIDTH'(1);
    localparam logic [LFST_WIDTH-1:0] SSIT_FIRST_ALLOC_ID = LFST_WIDTH'(2);

    typedef struct packed {
        logic [SSIT_WIDTH-1:0] ld_pc;
        logic [SSIT_WIDTH-1:0] st_pc;
        logic [LFST_WIDTH-1:0] ld_id;
        logic [LFST_WIDTH-1:0] st_id;
    } ssit_viol_t;

    typedef enum logic {
        SSIT_CLEAR = 1'b0,
        SSIT_IDLE  = 1'b1
    } ssit_ctrl_state_t;

    // IDs 0 (no set) and 1 (device set) are reserved, so wrap back to 2.
    function automatic logic [LFST_WIDTH-1:0] next_alloc(input logic [LFST_WIDTH-1:0] id);
        if (id == {LFST_WIDTH{1'b1}}) begin
            return SSIT_FIRST_ALLOC_ID;
        end else begin
            return id + LFST_WIDTH'(1);
        end
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push/pop are ignored when full/empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_s;
    logic             pop_s;

    assign full   = (count_r == (AW+1)'(DEPTH));
    assign empty  = (count_r == '0);
    assign count  = count_r;
    assign dout   = mem_r[rd_ptr_r];
    assign push_s = push & ~full;
    assign pop_s  = pop & ~empty;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ssit_update_ctrl.sv
// SSIT write-side controller: clear sweep, store-set merge/allocation and
// device pinning, arbitrated onto the table's two registered write ports.
module ssit_update_ctrl
    import Falco_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int CLEAR_INTERVAL = 65536
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  viol_valid,
    output logic                  viol_ready,
    input  logic [SSIT_WIDTH-1:0] viol_ld_pc,
    input  logic [SSIT_WIDTH-1:0] viol_st_pc,
    input  logic [LFST_WIDTH-1:0] viol_ld_id,
    input  logic [LFST_WIDTH-1:0] viol_st_id,
    input  logic                  dev_valid,
    output logic                  dev_ready,
    input  logic [SSIT_WIDTH-1:0] dev_pc,
    input  logic                  clear_req,
    output logic                  wr_a_en,
    output logic [SSIT_WIDTH-1:0] wr_a_addr,
    output logic [LFST_WIDTH-1:0] wr_a_data,
    output logic                  wr_b_en,
    output logic [SSIT_WIDTH-1:0] wr_b_addr,
    output logic [LFST_WIDTH-1:0] wr_b_data,
    output logic                  clearing
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    ssit_ctrl_state_t      state_r, state_s;
    logic [SSIT_WIDTH-2:0] sweep_idx_r, sweep_idx_s;
    logic [31:0]           interval_r, interval_s;
    logic [LFST_WIDTH-1:0] alloc_r, alloc_s;
    logic                  dev_full_r;
    logic [SSIT_WIDTH-1:0] dev_pc_r;
    logic                  dev_issue_s;

    ssit_viol_t            push_data_s;
    ssit_viol_t            head_s;
    logic                  fifo_push_s, fifo_pop_s;
    logic                  fifo_full_s, fifo_empty_s;
    logic [CNT_W-1:0]      fifo_count_s;

    logic                  a_en_s, b_en_s;
    logic [SSIT_WIDTH-1:0] a_addr_s, b_addr_s;
    logic [LFST_WIDTH-1:0] a_data_s, b_data_s;

    assign push_data_s = '{ld_pc: viol_ld_pc, st_pc: viol_st_pc, ld_id: viol_ld_id, st_id: viol_st_id};
    assign fifo_push_s = viol_valid & ~fifo_full_s;
    assign viol_ready  = (fifo_count_s != CNT_W'(FIFO_DEPTH));
    assign dev_ready   = ~dev_full_r;
    assign clearing    = (state_r == SSIT_CLEAR);

    sync_fifo #(
        .WIDTH ($bits(ssit_viol_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_viol_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .din   (push_data_s),
        .dout  (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Next-state, sweep/interval/allocator update and write-port selection.
    always_comb begin
        state_s     = state_r;
        sweep_idx_s = sweep_idx_r;
        interval_s  = interval_r;
        alloc_s     = alloc_r;
        dev_issue_s = 1'b0;
        fifo_pop_s  = 1'b0;
        a_en_s      = 1'b0;
        a_addr_s    = '0;
        a_data_s    = '0;
        b_en_s      = 1'b0;
        b_addr_s    = '0;
        b_data_s    = '0;
        case (state_r)
            SSIT_CLEAR: begin
                a_en_s   = 1'b1;
                a_addr_s = {sweep_idx_r, 1'b0};
                b_en_s   = 1'b1;
                b_addr_s = {sweep_idx_r, 1'b1};
                if (sweep_idx_r == {(SSIT_WIDTH-1){1'b1}}) begin
                    state_s     = SSIT_IDLE;
                    sweep_idx_s = '0;
                    interval_s  = '0;
                    alloc_s     = SSIT_FIRST_ALLOC_ID;
                end else begin
                    sweep_idx_s = sweep_idx_r + (SSIT_WIDTH-1)'(1);
                end
            end
            SSIT_IDLE: begin
                if (clear_req || (interval_r == 32'(CLEAR_INTERVAL - 1))) begin
                    state_s     = SSIT_CLEAR;
                    sweep_idx_s = '0;
                    interval_s  = '0;
                end else begin
                    interval_s = interval_r + 32'd1;
                end
                if (dev_full_r) begin
                    dev_issue_s = 1'b1;
                    a_en_s      = 1'b1;
                    a_addr_s    = dev_pc_r;
                    a_data_s    = SSIT_DEVICE_ID;
                end else if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    // Merge toward the larger ID; a zero ID is simply the smallest.
                    if ((head_s.ld_id == '0) && (head_s.st_id == '0)) begin
                        a_en_s   = 1'b1;
                        a_addr_s = head_s.ld_pc;
                        a_data_s = alloc_r;
                        b_en_s   = 1'b1;
                        b_addr_s = head_s.st_pc;
                        b_data_s = alloc_r;
                        alloc_s  = next_alloc(alloc_r);
                    end else if (head_s.ld_id < head_s.st_id) begin
                        a_en_s   = 1'b1;
                        a_addr_s = head_s.ld_pc;
                        a_data_s = head_s.st_id;
                    end else if (head_s.st_id < head_s.ld_id) begin
                        a_en_s   = 1'b1;
                        a_addr_s = head_s.st_pc;
                        a_data_s = head_s.ld_id;
                    end else begin
                        a_en_s = 1'b0;
                    end
                end else begin
                    dev_issue_s = 1'b0;
                end
            end
            default: begin
                state_s     = SSIT_CLEAR;
                sweep_idx_s = '0;
            end
        endcase
    end

    // Controller state, counters and registered write ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= SSIT_CLEAR;
            sweep_idx_r <= '0;
            interval_r  <= '0;
            alloc_r     <= SSIT_FIRST_ALLOC_ID;
            wr_a_en     <= 1'b0;
            wr_a_addr   <= '0;
            wr_a_data   <= '0;
            wr_b_en     <= 1'b0;
            wr_b_addr   <= '0;
            wr_b_data   <= '0;
        end else begin
            state_r     <= state_s;
            sweep_idx_r <= sweep_idx_s;
            interval_r  <= interval_s;
            alloc_r     <= alloc_s;
            wr_a_en     <= a_en_s;
            wr_a_addr   <= a_addr_s;
            wr_a_data   <= a_data_s;
            wr_b_en     <= b_en_s;
            wr_b_addr   <= b_addr_s;
            wr_b_data   <= b_data_s;
        end
    end

    // Single-entry device holding register; filled only when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            dev_full_r <= 1'b0;
            dev_pc_r   <= '0;
        end else if (dev_valid && !dev_full_r) begin
            dev_full_r <= 1'b1;
            dev_pc_r   <= dev_pc;
        end else if (dev_issue_s) begin
            dev_full_r <= 1'b0;
        end else begin
            dev_full_r <= dev_full_r;
        end
    end

endmodule

// File: tb/tb_ssit_update_ctrl.sv
// Directed bench for ssit_update_ctrl: sweep, merge rules, allocator wrap,
// device priority, FIFO back-pressure across a sweep and mid-sweep reset.
module tb_ssit_update_ctrl;
    import Falco_pkg::*;

    logic                  clk;
    logic                  rst;
    logic                  viol_valid;
    logic                  viol_ready;
    logic [SSIT_WIDTH-1:0] viol_ld_pc, viol_st_pc;
    logic [LFST_WIDTH-1:0] viol_ld_id, viol_st_id;
    logic                  dev_valid;
    logic                  dev_ready;
    logic [SSIT_WIDTH-1:0] dev_pc;
    logic                  clear_req;
    logic                  wr_a_en, wr_b_en;
    logic [SSIT_WIDTH-1:0] wr_a_addr, wr_b_addr;
    logic [LFST_WIDTH-1:0] wr_a_data, wr_b_data;
    logic                  clearing;

    int n_tests = 0;
    int n_fail  = 0;
    int clr_cnt;
    int n;

    ssit_update_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .viol_valid (viol_valid),
        .viol_ready (viol_ready),
        .viol_ld_pc (viol_ld_pc),
        .viol_st_pc (viol_st_pc),
        .viol_ld_id (viol_ld_id),
        .viol_st_id (viol_st_id),
        .dev_valid  (dev_valid),
        .dev_ready  (dev_ready),
        .dev_pc     (dev_pc),
        .clear_req  (clear_req),
        .wr_a_en    (wr_a_en),
        .wr_a_addr  (wr_a_addr),
        .wr_a_data  (wr_a_data),
        .wr_b_en    (wr_b_en),
        .wr_b_addr  (wr_b_addr),
        .wr_b_data  (wr_b_data),
        .clearing   (clearing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Write ports with address/data of a disabled port masked out.
    function automatic logic [63:0] wr_obs();
        return 64'({wr_a_en, wr_a_en ? wr_a_addr : 10'd0, wr_a_en ? wr_a_data : 11'd0,
                    wr_b_en, wr_b_en ? wr_b_addr : 10'd0, wr_b_en ? wr_b_data : 11'd0});
    endfunction

    task automatic expect_wr(input string tag,
                             input logic ae, input logic [9:0] aa, input logic [10:0] ad,
                             input logic be, input logic [9:0] ba, input logic [10:0] bd);
        cyc();
        check(tag, wr_obs(), 64'({ae, aa, ad, be, ba, bd}));
    endtask

    task automatic drive_viol(input logic [9:0] lp, input logic [9:0] sp,
                              input logic [10:0] li, input logic [10:0] si);
        viol_ld_pc = lp;
        viol_st_pc = sp;
        viol_ld_id = li;
        viol_st_id = si;
        viol_valid = 1'b1;
    endtask

    task automatic send_viol(input logic [9:0] lp, input logic [9:0] sp,
                             input logic [10:0] li, input logic [10:0] si);
        drive_viol(lp, sp, li, si);
        cyc();
        viol_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; viol_valid = 1'b0; viol_ld_pc = '0; viol_st_pc = '0;
        viol_ld_id = '0; viol_st_id = '0; dev_valid = 1'b0; dev_pc = '0; clear_req = 1'b0;
        cyc();
        check("rst_clearing", 64'(clearing), 64'd1);
        check("rst_wr_en", 64'({wr_a_en, wr_b_en}), 64'd0);
        check("rst_ready", 64'({viol_ready, dev_ready}), 64'd3);

        // Power-up sweep: 512 pairs of zero writes.
        rst = 1'b0;
        clr_cnt = 0;
        for (int k = 0; k < 512; k++) begin
            if (clearing) clr_cnt++;
            expect_wr("sweep_pair", 1'b1, 10'(2*k), 11'd0, 1'b1, 10'(2*k+1), 11'd0);
        end
        check("sweep_len", 64'(clr_cnt), 64'd512);
        check("sweep_done", 64'(clearing), 64'd0);
        expect_wr("idle_quiet", 1'b0, 10'd0, 11'd0, 1'b0, 10'd0, 11'd0);

        // New store sets from two zero-ID violations.
        send_viol(10'd5, 10'd9, 11'd0, 11'd0);
        check("viol_not_early", wr_obs(), 64'd0);
        expect_wr("alloc_2", 1'b1, 10'd5, 11'd2, 1'b1, 10'd9, 11'd2);
        send_viol(10'd11, 10'd13, 11'd0, 11'd0);
        expect_wr("alloc_3", 1'b1, 10'd11, 11'd3, 1'b1, 10'd13, 11'd3);

        // Merge toward the larger ID; equal IDs pop silently.
        send_viol(10'd20, 10'd30, 11'd7, 11'd4);
        expect_wr("merge_larger", 1'b1, 10'd30, 11'd7, 1'b0, 10'd0, 11'd0);
        send_viol(10'd50, 10'd60, 11'd6, 11'd6);
        send_viol(10'd70, 10'd80, 11'd0, 11'd3);
        check("equal_nowrite", wr_obs(), 64'd0);
        expect_wr("after_equal", 1'b1, 10'd70, 11'd3, 1'b0, 10'd0, 11'd0);

        // Device and violation accepted together; device issues first.
        drive_viol(10'd100, 10'd101, 11'd0, 11'd0);
        dev_pc = 10'd40;
        dev_valid = 1'b1;
        check("both_ready", 64'({viol_ready, dev_ready}), 64'd3);
        cyc();
        viol_valid = 1'b0;
        dev_valid = 1'b0;
        check("viol_ready_kept", 64'(viol_ready), 64'd1);
        expect_wr("dev_first", 1'b1, 10'd40, 11'd1, 1'b0, 10'd0, 11'd0);
        check("ready_after_dev", 64'({viol_ready, dev_ready}), 64'd3);
        expect_wr("viol_second", 1'b1, 10'd100, 11'd4, 1'b1, 10'd101, 11'd4);

        // Stream allocations 5..2046, then check the top ID and the wrap.
        drive_viol(10'd150, 10'd151, 11'd0, 11'd0);
        for (int i = 0; i < 2042; i++) cyc();
        viol_valid = 1'b0;
        cyc();
        cyc();
        send_viol(10'd200, 10'd201, 11'd0, 11'd0);
        expect_wr("alloc_max", 1'b1, 10'd200, 11'd2047, 1'b1, 10'd201, 11'd2047);
        send_viol(10'd202, 10'd203, 11'd0, 11'd0);
        expect_wr("alloc_wrap", 1'b1, 10'd202, 11'd2, 1'b1, 10'd203, 11'd2);

        // Forced sweep; fill the FIFO behind it with five requests.
        clear_req = 1'b1;
        cyc();
        clear_req = 1'b0;
        check("clear_req", 64'(clearing), 64'd1);
        for (int i = 0; i < 5; i++) begin
            drive_viol(10'(300+i), 10'(310+i), 11'd0, 11'(10+i));
            cyc();
            check("fill_ready", 64'(viol_ready), (i >= 3) ? 64'd0 : 64'd1);
        end
        viol_valid = 1'b0;
        n = 0;
        while (clearing && n < 600) begin cyc(); n++; end
        check("sweep2_end", 64'(clearing), 64'd0);
        for (int i = 0; i < 4; i++)
            expect_wr("queued_issue", 1'b1, 10'(300+i), 11'(10+i), 1'b0, 10'd0, 11'd0);
        expect_wr("fifth_dropped", 1'b0, 10'd0, 11'd0, 1'b0, 10'd0, 11'd0);
        check("ready_drained", 64'(viol_ready), 64'd1);

        // Forced sweep interrupted by reset at index 100.
        clear_req = 1'b1;
        cyc();
        clear_req = 1'b0;
        send_viol(10'd400, 10'd401, 11'd0, 11'd9);
        n = 0;
        while (!(wr_a_en && wr_a_addr == 10'd198) && n < 300) begin cyc(); n++; end
        check("reach_idx99", 64'({wr_a_en, wr_a_addr}), 64'({1'b1, 10'd198}));
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rst_mid_out", 64'({wr_a_en, wr_a_addr, wr_a_data, wr_b_en, wr_b_addr, wr_b_data}), 64'd0);
        check("rst_mid_clearing", 64'(clearing), 64'd1);
        check("rst_mid_ready", 64'({viol_ready, dev_ready}), 64'd3);
        expect_wr("restart_idx0", 1'b1, 10'd0, 11'd0, 1'b1, 10'd1, 11'd0);
        n = 0;
        while (clearing && n < 600) begin cyc(); n++; end
        check("sweep3_end", 64'(clearing), 64'd0);
        expect_wr("fifo_flushed", 1'b0, 10'd0, 11'd0, 1'b0, 10'd0, 11'd0);
        expect_wr("fifo_flushed2", 1'b0, 10'd0, 11'd0, 1'b0, 10'd0, 11'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
